// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of the single-port data memory; partial stores use read-modify-write.
// Optional build macro: DMEM_ARB_RR_EN selects round-robin arbitration instead of fixed port-0 priority.
module dmem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                m0_req,
  input  logic                m0_we,
  input  logic [DATA_W/8-1:0] m0_be,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  output logic                m0_gnt,
  output logic                m0_ack,
  output logic [DATA_W-1:0]   m0_rdata,
  input  logic                m1_req,
  input  logic                m1_we,
  input  logic [DATA_W/8-1:0] m1_be,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  output logic                m1_gnt,
  output logic                m1_ack,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int unsigned BE_W = DATA_W / 8;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_MERGE = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   merge_q, merge_d;
  logic [ADDR_W-1:0]   addr_q;
  logic                port_q;
  logic                ack0_q, ack1_q;
  logic [DATA_W-1:0]   rdata0_q, rdata1_q;
`ifdef DMEM_ARB_RR_EN
  logic                prio_q;
`endif

  logic                win0, win1, any_win;
  logic                sel_we;
  logic [BE_W-1:0]     sel_be;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic                be_full, be_none, be_partial;

  // Arbitration: only while idle and out of reset
  always_comb begin
    win0 = 1'b0;
    win1 = 1'b0;
    if (!rst && state_q == S_IDLE) begin
`ifdef DMEM_ARB_RR_EN
      if (m0_req && m1_req) begin
        win0 = !prio_q;
        win1 = prio_q;
      end else begin
        win0 = m0_req;
        win1 = m1_req;
      end
`else
      win0 = m0_req;
      win1 = m1_req && !m0_req;
`endif
    end
  end

  assign any_win    = win0 | win1;
  assign sel_we     = win1 ? m1_we    : m0_we;
  assign sel_be     = win1 ? m1_be    : m0_be;
  assign sel_addr   = win1 ? m1_addr  : m0_addr;
  assign sel_wdata  = win1 ? m1_wdata : m0_wdata;
  assign be_full    = (sel_be == {BE_W{1'b1}});
  assign be_none    = (sel_be == {BE_W{1'b0}});
  assign be_partial = !be_full && !be_none;
  assign m0_gnt     = win0;
  assign m1_gnt     = win1;

  // Memory drive and next-state
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = {ADDR_W{1'b0}};
    mem_wdata = {DATA_W{1'b0}};
    state_d   = state_q;
    for (int i = 0; i < int'(BE_W); i++) begin
      merge_d[i*8 +: 8] = sel_be[i] ? sel_wdata[i*8 +: 8] : mem_rdata[i*8 +: 8];
    end
    if (!rst) begin
      case (state_q)
        S_IDLE: begin
          if (any_win) begin
            if (!sel_we) begin
              mem_en   = 1'b1;
              mem_addr = sel_addr;
            end else if (be_full) begin
              mem_en    = 1'b1;
              mem_we    = 1'b1;
              mem_addr  = sel_addr;
              mem_wdata = sel_wdata;
            end else if (be_partial) begin
              mem_en   = 1'b1;
              mem_addr = sel_addr;
              state_d  = S_MERGE;
            end
          end
        end
        S_MERGE: begin
          mem_en    = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = addr_q;
          mem_wdata = merge_q;
          state_d   = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State, merge buffer, acks and read data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      merge_q  <= {DATA_W{1'b0}};
      addr_q   <= {ADDR_W{1'b0}};
      port_q   <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata0_q <= {DATA_W{1'b0}};
      rdata1_q <= {DATA_W{1'b0}};
`ifdef DMEM_ARB_RR_EN
      prio_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (any_win) begin
`ifdef DMEM_ARB_RR_EN
            prio_q <= !win1;
`endif
            if (sel_we && be_partial) begin
              merge_q <= merge_d;
              addr_q  <= sel_addr;
              port_q  <= win1;
            end else begin
              ack0_q <= win0;
              ack1_q <= win1;
              if (!sel_we && win0) rdata0_q <= mem_rdata;
              if (!sel_we && win1) rdata1_q <= mem_rdata;
            end
          end
        end
        S_MERGE: begin
          ack0_q <= !port_q;
          ack1_q <= port_q;
        end
        default: ;
      endcase
    end
  end

  assign m0_ack   = ack0_q;
  assign m1_ack   = ack1_q;
  assign m0_rdata = rdata0_q;
  assign m1_rdata = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a behavioural 1K-word memory.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [3:0]  m0_be, m1_be;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_ack, m1_gnt, m1_ack;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem [0:1023];
  logic        pl_en = 1'b0;
  logic [9:0]  pl_idx = 10'd0;
  logic [31:0] pl_data = 32'd0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_be(m0_be), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_be(m1_be), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  assign mem_rdata = mem[mem_addr[11:2]];

  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_data;
    else if (mem_en && mem_we) mem[mem_addr[11:2]] <= mem_wdata;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_req = 0; m0_we = 0; m0_be = 4'h0; m0_addr = 32'h0; m0_wdata = 32'h0;
    m1_req = 0; m1_we = 0; m1_be = 4'h0; m1_addr = 32'h0; m1_wdata = 32'h0;
  endtask

  task automatic preload(input logic [31:0] addr, input logic [31:0] data);
    pl_en = 1; pl_idx = addr[11:2]; pl_data = data;
    tick();
    pl_en = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    tick();
    rst = 0;
    tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    tick(); tick();
    checks++; if (m0_ack !== 1'b0 || m1_ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b/%b want 0/0", m0_ack, m1_ack); end
    checks++; if (m0_rdata !== 32'h0 || m1_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h/%h want 0/0", m0_rdata, m1_rdata); end
    checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL reset_mem_en: got %b want 0", mem_en); end
    rst = 0;
    tick();
    checks++; if (mem_en !== 1'b0 || m0_gnt !== 1'b0 || m1_gnt !== 1'b0) begin errors++; $display("FAIL idle_noreq: got en=%b g0=%b g1=%b want 0", mem_en, m0_gnt, m1_gnt); end
  endtask

  task automatic test_read();
    preload(32'h10, 32'hDEADBEEF);
    m0_req = 1; m0_we = 0; m0_be = 4'h0; m0_addr = 32'h10;
    #1;
    checks++; if (m0_gnt !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b0) begin errors++; $display("FAIL read_accept: got g=%b en=%b we=%b want 1 1 0", m0_gnt, mem_en, mem_we); end
    tick();
    m0_req = 0;
    checks++; if (m0_ack !== 1'b1 || m0_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL read_ack: got ack=%b rdata=%h want 1 deadbeef", m0_ack, m0_rdata); end
    checks++; if (m1_ack !== 1'b0) begin errors++; $display("FAIL read_other_ack: got %b want 0", m1_ack); end
    tick();
    checks++; if (m0_ack !== 1'b0 || m0_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL read_hold: got ack=%b rdata=%h want 0 deadbeef", m0_ack, m0_rdata); end
  endtask

  task automatic test_full_write();
    m0_req = 1; m0_we = 1; m0_be = 4'hF; m0_addr = 32'h30; m0_wdata = 32'hCAFEF00D;
    #1;
    checks++; if (m0_gnt !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 32'hCAFEF00D) begin errors++; $display("FAIL full_wr_drive: got g=%b we=%b wd=%h want 1 1 cafef00d", m0_gnt, mem_we, mem_wdata); end
    tick();
    m0_req = 0;
    checks++; if (m0_ack !== 1'b1 || mem[12] !== 32'hCAFEF00D) begin errors++; $display("FAIL full_wr_ack: got ack=%b word=%h want 1 cafef00d", m0_ack, mem[12]); end
    checks++; if (m0_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL full_wr_rdata: got %h want deadbeef", m0_rdata); end
  endtask

  task automatic test_byte_write();
    preload(32'h20, 32'h11223344);
    m1_req = 1; m1_we = 1; m1_be = 4'b0010; m1_addr = 32'h20; m1_wdata = 32'h0000AA00;
    #1;
    checks++; if (m1_gnt !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b0) begin errors++; $display("FAIL bw_read: got g=%b en=%b we=%b want 1 1 0", m1_gnt, mem_en, mem_we); end
    tick();
    m1_req = 0;
    #1;
    checks++; if (mem_we !== 1'b1 || mem_wdata !== 32'h1122AA44 || mem_addr !== 32'h20) begin errors++; $display("FAIL bw_merge: got we=%b wd=%h a=%h want 1 1122aa44 20", mem_we, mem_wdata, mem_addr); end
    checks++; if (m1_ack !== 1'b0) begin errors++; $display("FAIL bw_early_ack: got %b want 0", m1_ack); end
    tick();
    checks++; if (m1_ack !== 1'b1 || mem[8] !== 32'h1122AA44) begin errors++; $display("FAIL bw_done: got ack=%b word=%h want 1 1122aa44", m1_ack, mem[8]); end
    checks++; if (m1_rdata !== 32'h0) begin errors++; $display("FAIL bw_rdata: got %h want 0", m1_rdata); end
  endtask

  task automatic test_be_zero();
    m0_req = 1; m0_we = 1; m0_be = 4'h0; m0_addr = 32'h20; m0_wdata = 32'hFFFFFFFF;
    #1;
    checks++; if (m0_gnt !== 1'b1 || mem_en !== 1'b0) begin errors++; $display("FAIL be0_accept: got g=%b en=%b want 1 0", m0_gnt, mem_en); end
    tick();
    m0_req = 0;
    checks++; if (m0_ack !== 1'b1 || mem[8] !== 32'h1122AA44) begin errors++; $display("FAIL be0_ack: got ack=%b word=%h want 1 1122aa44", m0_ack, mem[8]); end
  endtask

  task automatic test_conflict();
    logic exp0;
    do_reset();
    m0_req = 1; m0_we = 0; m0_addr = 32'h10;
    m1_req = 1; m1_we = 0; m1_addr = 32'h20;
    for (int c = 0; c < 4; c++) begin
`ifdef DMEM_ARB_RR_EN
      exp0 = (c % 2 == 0);
`else
      exp0 = 1'b1;
`endif
      #1;
      checks++; if (m0_gnt !== exp0 || m1_gnt !== !exp0) begin errors++; $display("FAIL conflict_gnt%0d: got %b/%b want %b/%b", c, m0_gnt, m1_gnt, exp0, !exp0); end
      tick();
      checks++; if (m0_ack !== exp0 || m1_ack !== !exp0) begin errors++; $display("FAIL conflict_ack%0d: got %b/%b want %b/%b", c, m0_ack, m1_ack, exp0, !exp0); end
      if (exp0) begin
        checks++; if (m0_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL conflict_rd0_%0d: got %h want deadbeef", c, m0_rdata); end
      end else begin
        checks++; if (m1_rdata !== 32'h1122AA44) begin errors++; $display("FAIL conflict_rd1_%0d: got %h want 1122aa44", c, m1_rdata); end
      end
    end
    m0_req = 0;
    #1;
    checks++; if (m1_gnt !== 1'b1) begin errors++; $display("FAIL conflict_release: got %b want 1", m1_gnt); end
    tick();
    m1_req = 0;
    checks++; if (m1_ack !== 1'b1 || m1_rdata !== 32'h1122AA44) begin errors++; $display("FAIL conflict_m1_ack: got ack=%b rd=%h want 1 1122aa44", m1_ack, m1_rdata); end
  endtask

  task automatic test_busy_holdoff();
    m0_req = 1; m0_we = 1; m0_be = 4'b0001; m0_addr = 32'h30; m0_wdata = 32'h000000EE;
    #1;
    checks++; if (m0_gnt !== 1'b1 || mem_we !== 1'b0) begin errors++; $display("FAIL hold_accept: got g=%b we=%b want 1 0", m0_gnt, mem_we); end
    tick();
    m0_req = 0;
    m1_req = 1; m1_we = 0; m1_addr = 32'h30;
    #1;
    checks++; if (m1_gnt !== 1'b0 || m0_gnt !== 1'b0) begin errors++; $display("FAIL hold_gnt: got %b/%b want 0/0", m0_gnt, m1_gnt); end
    checks++; if (mem_we !== 1'b1 || mem_wdata !== 32'hCAFEF0EE) begin errors++; $display("FAIL hold_merge: got we=%b wd=%h want 1 cafef0ee", mem_we, mem_wdata); end
    tick();
    checks++; if (m0_ack !== 1'b1) begin errors++; $display("FAIL hold_m0_ack: got %b want 1", m0_ack); end
    #1;
    checks++; if (m1_gnt !== 1'b1) begin errors++; $display("FAIL hold_m1_gnt: got %b want 1", m1_gnt); end
    tick();
    m1_req = 0;
    checks++; if (m1_ack !== 1'b1 || m1_rdata !== 32'hCAFEF0EE) begin errors++; $display("FAIL hold_m1_ack: got ack=%b rd=%h want 1 cafef0ee", m1_ack, m1_rdata); end
  endtask

  task automatic test_reset_merge();
    m1_req = 1; m1_we = 1; m1_be = 4'b1000; m1_addr = 32'h10; m1_wdata = 32'h55000000;
    #1;
    checks++; if (m1_gnt !== 1'b1) begin errors++; $display("FAIL rstm_accept: got %b want 1", m1_gnt); end
    tick();
    m1_req = 0;
    rst = 1;
    #1;
    checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL rstm_mem_en: got %b want 0", mem_en); end
    tick();
    checks++; if (mem[4] !== 32'hDEADBEEF) begin errors++; $display("FAIL rstm_word: got %h want deadbeef", mem[4]); end
    checks++; if (m0_ack !== 1'b0 || m1_ack !== 1'b0 || m0_rdata !== 32'h0 || m1_rdata !== 32'h0) begin errors++; $display("FAIL rstm_outputs: got ack=%b/%b rd=%h/%h want 0", m0_ack, m1_ack, m0_rdata, m1_rdata); end
    rst = 0;
    tick();
    checks++; if (m1_ack !== 1'b0 || mem_en !== 1'b0 || mem[4] !== 32'hDEADBEEF) begin errors++; $display("FAIL rstm_after: got ack=%b en=%b word=%h want 0 0 deadbeef", m1_ack, mem_en, mem[4]); end
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    #1;
    test_reset();
    test_read();
    test_full_write();
    test_byte_write();
    test_be_zero();
    test_conflict();
    test_busy_holdoff();
    test_reset_merge();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
